// File: rtl/command_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : command_register_bank
// Description : Decodes a window of NUM_REGS command registers from the
//               16-bit command word stream. Values DATA_WIDTH wide are built
//               from 4-bit nibbles (most significant first) and committed
//               atomically. Each commit raises a per-register update strobe.
//               Registers flagged in PULSE_MASK return to their default one
//               cycle after a commit. An interrupted or stalled sequence
//               raises a one-cycle error strobe.
//
// Ports       : Clk          - system clock
//               reset_n      - asynchronous active-low reset
//               CommandEn    - CommandWord valid this cycle
//               CommandWord  - [15:4] address, [3:0] data nibble
//               RegOut       - committed values, slice i = register i
//               UpdatePulse  - one-cycle strobe per register on commit
//               CommandError - one-cycle strobe on abort / timeout / bad read
//               Busy         - a sequence is being collected
//               ReadbackData - (CMD_READBACK_EN) selected register value
//               ReadbackValid- (CMD_READBACK_EN) one-cycle readback strobe
//
// Options     : `define CMD_READBACK_EN adds the readback command at address
//               BASE_ADDRESS+NUM_REGS; the nibble selects the register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module command_register_bank #(
    parameter int                             NUM_REGS       = 8,
    parameter logic [11:0]                    BASE_ADDRESS   = 12'hA00,
    parameter int                             DATA_WIDTH     = 16,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] DEFAULT_VALUES = '0,
    parameter logic [NUM_REGS-1:0]            PULSE_MASK     = '0,
    parameter int                             TIMEOUT_CYCLES = 1024
) (
    input  logic                           Clk,
    input  logic                           reset_n,
    input  logic                           CommandEn,
    input  logic [15:0]                    CommandWord,
    output logic [NUM_REGS*DATA_WIDTH-1:0] RegOut,
    output logic [NUM_REGS-1:0]            UpdatePulse,
    output logic                           CommandError,
`ifdef CMD_READBACK_EN
    output logic [DATA_WIDTH-1:0]          ReadbackData,
    output logic                           ReadbackValid,
`endif
    output logic                           Busy
);

    localparam int          c_nibbles   = DATA_WIDTH / 4;
    localparam int          c_tmr_w     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [11:0] c_last_addr = BASE_ADDRESS + 12'(NUM_REGS - 1);

    localparam logic [0:0]  c_st_idle    = 1'b0;
    localparam logic [0:0]  c_st_collect = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic [11:0]           w_addr;
    logic [3:0]            w_nibble;
    logic [3:0]            w_idx;
    logic                  w_hit;

    logic [DATA_WIDTH-1:0] r_stage;
    logic [DATA_WIDTH-1:0] w_stage_shift;
    logic [3:0]            r_idx;
    logic [3:0]            r_count;
    logic                  w_last_nibble;
    logic [c_tmr_w-1:0]    r_timer;
    logic [c_tmr_w-1:0]    w_timer_next;
    logic                  w_expire;

    logic                  w_load_first;
    logic                  w_shift;
    logic                  w_commit;
    logic                  w_seq_err;
    logic                  w_tick;
    logic                  w_abandon;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_update_next;
    logic [NUM_REGS-1:0]   r_update;
    logic                  r_error;
    logic                  w_rb_err;

    assign w_addr   = CommandWord[15:4];
    assign w_nibble = CommandWord[3:0];
    assign w_hit    = CommandEn && (w_addr >= BASE_ADDRESS) && (w_addr <= c_last_addr);
    assign w_idx    = 4'(w_addr - BASE_ADDRESS);

    assign w_last_nibble = (r_count == 4'(c_nibbles - 1));
    assign w_timer_next  = r_timer + c_tmr_w'(1);
    // A zero TIMEOUT_CYCLES never expires; the idle counter may wrap harmlessly.
    assign w_expire      = (TIMEOUT_CYCLES != 0) && (w_timer_next == c_tmr_w'(TIMEOUT_CYCLES));

    // A 4-bit register has nothing to shift: the nibble is the whole value.
    generate
        if (DATA_WIDTH > 4) begin : g_shift_wide
            assign w_stage_shift = {r_stage[DATA_WIDTH-5:0], w_nibble};
        end else begin : g_shift_narrow
            assign w_stage_shift = w_nibble;
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_st_idle;
        else          r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_hit && (c_nibbles > 1)) w_state_next = c_st_collect;
            end
            c_st_collect: begin
                if (w_hit) begin
                    if (w_idx == r_idx) begin
                        if (w_last_nibble) w_state_next = c_st_idle;
                    end else if (c_nibbles == 1) begin
                        w_state_next = c_st_idle;
                    end
                end else if (w_expire) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        w_load_first = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_seq_err    = 1'b0;
        w_tick       = 1'b0;
        w_abandon    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_hit) begin
                    w_load_first = 1'b1;
                    w_commit     = (c_nibbles == 1);
                end
            end
            c_st_collect: begin
                if (w_hit) begin
                    if (w_idx == r_idx) begin
                        w_shift  = 1'b1;
                        w_commit = w_last_nibble;
                    end else begin
                        // Switching register mid-sequence: flag it, restart.
                        w_seq_err    = 1'b1;
                        w_load_first = 1'b1;
                        w_commit     = (c_nibbles == 1);
                    end
                end else if (w_expire) begin
                    w_seq_err = 1'b1;
                    w_abandon = 1'b1;
                end else begin
                    w_tick = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- staging / sequence bookkeeping ----------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_timer <= '0;
        end else begin
            if (w_load_first) begin
                r_stage <= DATA_WIDTH'(w_nibble);
                r_idx   <= w_idx;
                r_count <= 4'd1;
                r_timer <= '0;
            end else if (w_shift) begin
                r_stage <= w_stage_shift;
                r_count <= r_count + 4'd1;
                r_timer <= '0;
            end else if (w_tick) begin
                r_timer <= w_timer_next;
            end
            if (w_commit || w_abandon) begin
                r_stage <= '0;
                r_count <= '0;
                r_timer <= '0;
            end
        end
    end

    // ---------------- register bank ----------------
    // Commits always carry the idx of the current word: a shift implies the
    // same idx, and a first nibble only commits when it is the whole value.
    always_comb begin
        w_update_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_update_next[i] = w_commit && (w_idx == 4'(i));
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= DEFAULT_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_update <= '0;
            r_error  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // A fresh commit outranks the auto-clear of a pulse register.
                if (w_update_next[i])
                    r_regs[i] <= w_stage_shift;
                else if (PULSE_MASK[i] && r_update[i])
                    r_regs[i] <= DEFAULT_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_update <= w_update_next;
            r_error  <= w_seq_err || w_rb_err;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regout
            assign RegOut[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign UpdatePulse  = r_update;
    assign CommandError = r_error;
    assign Busy         = (r_state == c_st_collect);

    // ---------------- optional readback ----------------
`ifdef CMD_READBACK_EN
    localparam logic [11:0] c_rb_addr = BASE_ADDRESS + 12'(NUM_REGS);

    logic                  w_rb_cmd;
    logic                  w_rb_ok;
    logic [DATA_WIDTH-1:0] w_rb_sel;
    logic [DATA_WIDTH-1:0] r_rb_data;
    logic                  r_rb_valid;

    // The readback address is outside the hit window, so the collector sees
    // it as an idle cycle and its timeout keeps running.
    assign w_rb_cmd = CommandEn && (w_addr == c_rb_addr);
    assign w_rb_ok  = (w_nibble < 4'(NUM_REGS));
    assign w_rb_err = w_rb_cmd && !w_rb_ok;

    always_comb begin
        w_rb_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_nibble == 4'(i)) w_rb_sel = r_regs[i];
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= w_rb_cmd && w_rb_ok;
            if (w_rb_cmd && w_rb_ok) r_rb_data <= w_rb_sel;
        end
    end

    assign ReadbackData  = r_rb_data;
    assign ReadbackValid = r_rb_valid;
`else
    assign w_rb_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_command_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_register_bank
// Description : Self-checking bench for command_register_bank. Directed
//               scenarios plus a randomized command stream, all compared
//               against a behavioural model of the register window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_register_bank;

    localparam int               NR       = 8;
    localparam int               DW       = 16;
    localparam int               NIB      = DW / 4;
    localparam int               TO       = 16;
    localparam logic [11:0]      BASE     = 12'hA00;
    localparam logic [NR*DW-1:0] DEFAULTS = {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                             16'h0000, 16'h00FF, 16'h0000, 16'h0000};
    localparam logic [NR-1:0]    PMASK    = 8'h80;

    logic             Clk = 1'b0;
    logic             reset_n;
    logic             CommandEn;
    logic [15:0]      CommandWord;
    logic [NR*DW-1:0] RegOut;
    logic [NR-1:0]    UpdatePulse;
    logic             CommandError;
    logic             Busy;
`ifdef CMD_READBACK_EN
    logic [DW-1:0]    ReadbackData;
    logic             ReadbackValid;
`endif

    int checks   = 0;
    int failures = 0;

    command_register_bank #(
        .NUM_REGS       (NR),
        .BASE_ADDRESS   (BASE),
        .DATA_WIDTH     (DW),
        .DEFAULT_VALUES (DEFAULTS),
        .PULSE_MASK     (PMASK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .CommandEn    (CommandEn),
        .CommandWord  (CommandWord),
        .RegOut       (RegOut),
        .UpdatePulse  (UpdatePulse),
        .CommandError (CommandError),
`ifdef CMD_READBACK_EN
        .ReadbackData (ReadbackData),
        .ReadbackValid(ReadbackValid),
`endif
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0]    m_regs [NR];
    bit               m_active;
    int               m_idx;
    int               m_idle;
    int               m_nibs [$];
    logic [NR-1:0]    e_update;
    bit               e_error;
    logic [DW-1:0]    e_rb_data;
    bit               e_rb_valid;
    logic [NR*DW-1:0] e_flat;

    function automatic logic [DW-1:0] default_of(int i);
        logic [NR*DW-1:0] d;
        d = DEFAULTS;
        return d[i*DW +: DW];
    endfunction

    task automatic build_flat();
        for (int i = 0; i < NR; i++) e_flat[i*DW +: DW] = m_regs[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = default_of(i);
        m_active = 0; m_idx = 0; m_idle = 0; m_nibs.delete();
        e_update = '0; e_error = 0; e_rb_data = '0; e_rb_valid = 0;
        build_flat();
    endtask

    // Advances the model by one clock given this cycle's command.
    task automatic model_step(input bit en, input logic [15:0] word);
        logic [DW-1:0] snap [NR];
        logic [NR-1:0] upd;
        logic [DW-1:0] val;
        int addr, nib, idx;
        bit err;
        upd = '0; err = 0;
        addr = int'(word[15:4]);
        nib  = int'(word[3:0]);
        for (int i = 0; i < NR; i++) snap[i] = m_regs[i];
        for (int i = 0; i < NR; i++)
            if (e_update[i] && PMASK[i]) m_regs[i] = default_of(i);
        if (en && addr >= int'(BASE) && addr < int'(BASE) + NR) begin
            idx = addr - int'(BASE);
            if (m_active && idx != m_idx) begin err = 1; m_active = 0; end
            if (!m_active) begin m_active = 1; m_idx = idx; m_nibs.delete(); end
            m_nibs.push_back(nib);
            m_idle = 0;
            if (m_nibs.size() == NIB) begin
                val = '0;
                foreach (m_nibs[k]) val = val * 16 + DW'(m_nibs[k]);
                m_regs[m_idx] = val;
                upd[m_idx] = 1'b1;
                m_active = 0;
            end
        end else if (m_active) begin
            m_idle++;
            if (m_idle == TO) begin err = 1; m_active = 0; end
        end
        e_rb_valid = 0;
`ifdef CMD_READBACK_EN
        if (en && addr == int'(BASE) + NR) begin
            if (nib < NR) begin e_rb_valid = 1; e_rb_data = snap[nib]; end
            else err = 1;
        end
`endif
        e_update = upd;
        e_error  = err;
        build_flat();
    endtask

    // Apply one command for one clock; returns #1 after the sampling edge.
    task automatic drive(input bit en, input logic [15:0] word);
        CommandEn   = en;
        CommandWord = word;
        model_step(en, word);
        @(posedge Clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; CommandEn = 1'b0; CommandWord = '0;
        repeat (3) @(posedge Clk);
        #1 reset_n = 1'b1;
        model_reset();
        drive(0, 16'h0000);
        checks++; if (RegOut !== DEFAULTS) begin failures++; $display("FAIL reset_regout got=%h exp=%h", RegOut, DEFAULTS); end
        checks++; if (RegOut[47:32] !== 16'h00FF) begin failures++; $display("FAIL reset_reg2 got=%h exp=00ff", RegOut[47:32]); end
        checks++; if (UpdatePulse !== 8'h00) begin failures++; $display("FAIL reset_update got=%h exp=00", UpdatePulse); end
        checks++; if (CommandError !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", CommandError); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_commit();
        drive(1, 16'hA021);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL commit_busy_start got=%b exp=1", Busy); end
        drive(1, 16'hA022);
        repeat (5) drive(0, 16'h0000);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL commit_busy_gap got=%b exp=1", Busy); end
        checks++; if (UpdatePulse !== 8'h00) begin failures++; $display("FAIL commit_early_update got=%h exp=00", UpdatePulse); end
        drive(1, 16'hA023);
        drive(1, 16'hA024);
        checks++; if (RegOut[47:32] !== 16'h1234) begin failures++; $display("FAIL commit_value got=%h exp=1234", RegOut[47:32]); end
        checks++; if (UpdatePulse !== 8'h04) begin failures++; $display("FAIL commit_update got=%h exp=04", UpdatePulse); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL commit_busy_end got=%b exp=0", Busy); end
        drive(0, 16'h0000);
        checks++; if (UpdatePulse !== 8'h00) begin failures++; $display("FAIL commit_update_len got=%h exp=00", UpdatePulse); end
        checks++; if (RegOut[47:32] !== 16'h1234) begin failures++; $display("FAIL commit_hold got=%h exp=1234", RegOut[47:32]); end
    endtask

`ifdef CMD_READBACK_EN
    task automatic test_readback();
        drive(1, 16'hA082);
        checks++; if (ReadbackValid !== 1'b1) begin failures++; $display("FAIL rb_valid got=%b exp=1", ReadbackValid); end
        checks++; if (ReadbackData !== 16'h1234) begin failures++; $display("FAIL rb_data got=%h exp=1234", ReadbackData); end
        drive(0, 16'h0000);
        checks++; if (ReadbackValid !== 1'b0) begin failures++; $display("FAIL rb_valid_len got=%b exp=0", ReadbackValid); end
        drive(1, 16'hA08F);
        checks++; if (CommandError !== 1'b1) begin failures++; $display("FAIL rb_bad_error got=%b exp=1", CommandError); end
        checks++; if (ReadbackValid !== 1'b0) begin failures++; $display("FAIL rb_bad_valid got=%b exp=0", ReadbackValid); end
        drive(0, 16'h0000);
        checks++; if (CommandError !== 1'b0) begin failures++; $display("FAIL rb_error_len got=%b exp=0", CommandError); end
    endtask
`endif

    task automatic test_abort();
        drive(1, 16'hA031);
        drive(1, 16'hA032);
        drive(1, 16'hA05F);
        checks++; if (CommandError !== 1'b1) begin failures++; $display("FAIL abort_error got=%b exp=1", CommandError); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", Busy); end
        checks++; if (RegOut[63:48] !== 16'h0000) begin failures++; $display("FAIL abort_reg3 got=%h exp=0000", RegOut[63:48]); end
        drive(0, 16'h0000);
        checks++; if (CommandError !== 1'b0) begin failures++; $display("FAIL abort_error_len got=%b exp=0", CommandError); end
        drive(1, 16'hA050);
        drive(1, 16'hA051);
        drive(1, 16'hA052);
        checks++; if (RegOut[95:80] !== 16'hF012) begin failures++; $display("FAIL abort_reg5 got=%h exp=f012", RegOut[95:80]); end
        checks++; if (UpdatePulse !== 8'h20) begin failures++; $display("FAIL abort_update got=%h exp=20", UpdatePulse); end
    endtask

    task automatic test_timeout();
        drive(1, 16'hA061);
        repeat (TO - 1) drive(0, 16'h0000);
        checks++; if (Busy !== 1'b1 || CommandError !== 1'b0) begin failures++; $display("FAIL to_pre busy=%b err=%b exp busy=1 err=0", Busy, CommandError); end
        drive(0, 16'h0000);
        checks++; if (CommandError !== 1'b1) begin failures++; $display("FAIL to_error got=%b exp=1", CommandError); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", Busy); end
        checks++; if (RegOut[111:96] !== 16'h0000) begin failures++; $display("FAIL to_reg6 got=%h exp=0000", RegOut[111:96]); end
        drive(0, 16'h0000);
        checks++; if (CommandError !== 1'b0) begin failures++; $display("FAIL to_error_len got=%b exp=0", CommandError); end
        drive(1, 16'hA061);
        repeat (TO - 1) drive(0, 16'h0000);
        drive(1, 16'hA062);
        checks++; if (CommandError !== 1'b0) begin failures++; $display("FAIL to_edge_error got=%b exp=0", CommandError); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL to_edge_busy got=%b exp=1", Busy); end
        drive(1, 16'hA063);
        drive(1, 16'hA064);
        checks++; if (RegOut[111:96] !== 16'h1234) begin failures++; $display("FAIL to_edge_reg6 got=%h exp=1234", RegOut[111:96]); end
    endtask

    task automatic test_pulse();
        drive(1, 16'hA079);
        drive(1, 16'hA07A);
        drive(1, 16'hA07B);
        drive(1, 16'hA07C);
        checks++; if (RegOut[127:112] !== 16'h9ABC) begin failures++; $display("FAIL pulse_value got=%h exp=9abc", RegOut[127:112]); end
        checks++; if (UpdatePulse !== 8'h80) begin failures++; $display("FAIL pulse_update got=%h exp=80", UpdatePulse); end
        drive(0, 16'h0000);
        checks++; if (RegOut[127:112] !== 16'h0000) begin failures++; $display("FAIL pulse_clear got=%h exp=0000", RegOut[127:112]); end
        checks++; if (UpdatePulse !== 8'h00) begin failures++; $display("FAIL pulse_update_len got=%h exp=00", UpdatePulse); end
    endtask

    task automatic test_random();
        int sidx, idle_run, r;
        logic [11:0] addr;
        logic [3:0]  nib;
        sidx = 0; idle_run = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r   = int'($urandom_range(0, 99));
            nib = 4'($urandom_range(0, 15));
            if (idle_run > 0) begin
                idle_run--;
                drive(0, 16'h0000);
            end else if (r < 4) begin
                idle_run = TO + 1;
                drive(0, 16'h0000);
            end else if (r < 60) begin
                if ($urandom_range(0, 9) == 0) sidx = int'($urandom_range(0, NR - 1));
                addr = BASE + 12'(sidx);
                drive(1, {addr, nib});
            end else if (r < 70) begin
                addr = BASE + 12'(NR);
                drive(1, {addr, nib});
            end else if (r < 80) begin
                addr = 12'($urandom_range(0, 12'h7FF));
                drive(1, {addr, nib});
            end else begin
                drive(0, 16'($urandom));
            end
            checks++; if (RegOut !== e_flat) begin failures++; $display("FAIL rand_regout cyc=%0d got=%h exp=%h", cyc, RegOut, e_flat); end
            checks++; if (UpdatePulse !== e_update) begin failures++; $display("FAIL rand_update cyc=%0d got=%h exp=%h", cyc, UpdatePulse, e_update); end
            checks++; if (CommandError !== e_error) begin failures++; $display("FAIL rand_error cyc=%0d got=%b exp=%b", cyc, CommandError, e_error); end
            checks++; if (Busy !== m_active) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, Busy, m_active); end
`ifdef CMD_READBACK_EN
            checks++; if (ReadbackValid !== e_rb_valid) begin failures++; $display("FAIL rand_rb_valid cyc=%0d got=%b exp=%b", cyc, ReadbackValid, e_rb_valid); end
            checks++; if (ReadbackData !== e_rb_data) begin failures++; $display("FAIL rand_rb_data cyc=%0d got=%h exp=%h", cyc, ReadbackData, e_rb_data); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 16'hA071);
        drive(1, 16'hA072);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (RegOut !== DEFAULTS) begin failures++; $display("FAIL rmid_regout got=%h exp=%h", RegOut, DEFAULTS); end
        checks++; if (UpdatePulse !== 8'h00 || CommandError !== 1'b0) begin failures++; $display("FAIL rmid_strobes upd=%h err=%b exp 00/0", UpdatePulse, CommandError); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", Busy); end
        repeat (2) @(posedge Clk);
        #1 reset_n = 1'b1;
        model_reset();
        drive(1, 16'hA073);
        drive(1, 16'hA074);
        checks++; if (Busy !== 1'b1 || UpdatePulse !== 8'h00) begin failures++; $display("FAIL rmid_restart busy=%b upd=%h exp 1/00", Busy, UpdatePulse); end
        drive(1, 16'hA075);
        drive(1, 16'hA076);
        checks++; if (RegOut[127:112] !== 16'h3456) begin failures++; $display("FAIL rmid_value got=%h exp=3456", RegOut[127:112]); end
        checks++; if (UpdatePulse !== 8'h80) begin failures++; $display("FAIL rmid_update got=%h exp=80", UpdatePulse); end
        drive(0, 16'h0000);
        checks++; if (RegOut[127:112] !== 16'h0000) begin failures++; $display("FAIL rmid_clear got=%h exp=0000", RegOut[127:112]); end
    endtask

    initial begin
        test_reset();
        test_commit();
`ifdef CMD_READBACK_EN
        test_readback();
`endif
        test_abort();
        test_timeout();
        test_pulse();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
